// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing one SD block channel of the HPS bridge among NUM drive requesters.
// The winner's command is latched, and ack/buffer strobes are routed back to it only.
module sd_block_arbiter #(
    parameter int          NUM     = 2,
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [32*NUM-1:0]   req_lba,
    input  logic [NUM-1:0]      req_rd,
    input  logic [NUM-1:0]      req_wr,
    output logic [NUM-1:0]      req_ack,
    output logic [NUM-1:0]      req_buff_wr,
    input  logic [8*NUM-1:0]    req_buff_din,
    output logic [NUM-1:0]      req_err,
    output logic [31:0]         sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    input  logic                sd_buff_wr,
    output logic [7:0]          sd_buff_din,
    output logic [1:0]          grant,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_rr;
    logic [1:0]      r_grant;
    logic [23:0]     r_cnt;
    logic [31:0]     r_lba;
    logic            r_rd;
    logic            r_wr;
    logic [NUM-1:0]  r_err;

    logic [NUM-1:0][31:0] w_lba;
    logic [NUM-1:0][7:0]  w_din;
    logic [NUM-1:0]       w_pend;
    logic [NUM-1:0]       w_gsel;
    logic                 w_found;
    logic [1:0]           w_idx;
    logic [31:0]          w_lba_sel;
    logic                 w_rd_sel;
    logic                 w_wr_sel;
    logic [7:0]           w_din_sel;
    logic                 w_busy;
    logic                 w_tmo;

    assign w_lba  = req_lba;
    assign w_din  = req_buff_din;
    assign w_pend = req_rd | req_wr;
    assign w_busy = (r_state != S_IDLE);
    assign w_tmo  = (TIMEOUT != 24'd0) && (r_cnt == TIMEOUT - 24'd1);

    // Scan order rr_ptr, rr_ptr+1, ... with wrap; first pending slot wins.
    always_comb begin
        w_found   = 1'b0;
        w_idx     = 2'd0;
        w_lba_sel = 32'd0;
        w_rd_sel  = 1'b0;
        w_wr_sel  = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            for (int i = 0; i < NUM; i++) begin
                if (!w_found && w_pend[i] && (i == (int'(r_rr) + k) % NUM)) begin
                    w_found   = 1'b1;
                    w_idx     = 2'(i);
                    w_lba_sel = w_lba[i];
                    w_rd_sel  = req_rd[i];
                    w_wr_sel  = req_wr[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_slot
        assign w_gsel[g]      = (r_grant == 2'(g));
        assign req_ack[g]     = sd_ack & w_gsel[g] & w_busy;
        assign req_buff_wr[g] = sd_buff_wr & w_gsel[g] & w_busy;
    end

    always_comb begin
        w_din_sel = 8'd0;
        for (int i = 0; i < NUM; i++) begin
            if (w_gsel[i]) w_din_sel = w_din[i];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_rr    <= 2'd0;
            r_grant <= 2'd0;
            r_cnt   <= 24'd0;
            r_lba   <= 32'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= '0;
        end else begin
            r_err <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_idx;
                        r_lba   <= w_lba_sel;
                        r_rd    <= w_rd_sel & ~w_wr_sel;
                        r_wr    <= w_wr_sel;
                        r_cnt   <= 24'd0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack already high on entry is taken as the ack.
                    if (sd_ack) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= S_XFER;
                    end else if (w_tmo) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_err   <= w_gsel;
                        r_state <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end
                S_XFER: begin
                    if (!sd_ack) r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // One idle-bound cycle so the owner's dropped rd/wr is not re-sampled.
                    r_rr    <= (int'(r_grant) == NUM - 1) ? 2'd0 : r_grant + 2'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sd_lba      = r_lba;
    assign sd_rd       = r_rd;
    assign sd_wr       = r_wr;
    assign grant       = r_grant;
    assign busy        = w_busy;
    assign req_err     = r_err;
    assign sd_buff_din = w_din_sel;

endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Shares the single SD block-level channel of the HPS I/O bridge among NUM independent virtual-drive requesters (e.g. floppy A/B, HDD).
- The channel consists of sd_lba, sd_rd, sd_wr, sd_ack, sd_buff_wr and sd_buff_din.
- Arbitration is round-robin. The winner's LBA and command are latched and presented to the bridge, sd_ack and buffer strobes are routed back to the winner, and a wait-for-ack timeout keeps a dead host from hanging the core.
- Sits between the drive controllers and the bridge's SD ports, in the clk_sys domain.

Parameters:
- NUM, 2: number of requesters (2..4).
- TIMEOUT, 24'd12000000: clk_sys cycles to wait for sd_ack rise before aborting. 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_lba  in  32*NUM  per-requester LBA; slot i is bits [32i+31:32i].
- req_rd  in  NUM  per-requester read request, level.
- req_wr  in  NUM  per-requester write request, level.
- req_ack  out  NUM  per-requester ack; a copy of sd_ack gated to the granted slot.
- req_buff_wr  out  NUM  sd_buff_wr gated to the granted slot.
- req_buff_din  in  8*NUM  per-requester write-data byte for the bridge.
- req_err  out  NUM  1-cycle pulse to the granted slot on timeout.
- sd_lba  out  32  to bridge.
- sd_rd  out  1  to bridge.
- sd_wr  out  1  to bridge.
- sd_ack  in  1  from bridge.
- sd_buff_wr  in  1  from bridge.
- sd_buff_din  out  8  to bridge; the granted slot's req_buff_din.
- grant  out  2  index of the current or last owner.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; timeout counter=0.
- sd_ack and sd_buff_wr are used directly; they come from the same clk_sys domain.
- State IDLE:
  - pending[i] = req_rd[i] | req_wr[i].
  - If any slot is pending, pick the first pending index scanning from rr_ptr upward with wrap.
  - On that edge: grant<=idx; sd_lba<=req_lba[idx]; sd_rd<=req_rd[idx]&~req_wr[idx]; sd_wr<=req_wr[idx].
  - Write wins if rd and wr are both set. Go to REQ; busy=1 from the next cycle.
- State REQ:
  - Hold sd_lba, sd_rd, sd_wr and count cycles.
  - On sd_ack=1: clear sd_rd and sd_wr on the same edge, then go to XFER.
  - If count reaches TIMEOUT with sd_ack still 0 (TIMEOUT≠0): clear sd_rd and sd_wr, pulse req_err[grant] for one cycle, go to RELEASE.
- State XFER:
  - Remains while sd_ack=1. On sd_ack falling to 0, go to RELEASE.
- State RELEASE:
  - rr_ptr<=grant+1, wrapping at NUM.
  - Wait one cycle, then go to IDLE, so the requester's rd/wr, dropped on its ack, is not re-sampled.
  - The requester is still pending after an abort and re-arbitrates fairly.
- Routing (combinational, all states):
  - req_ack[i] = sd_ack & (grant==i) & busy.
  - req_buff_wr[i] = sd_buff_wr & (grant==i) & busy.
  - sd_buff_din = req_buff_din[grant].
  - Non-granted slots see 0 on ack and buff_wr.
- sd_lba is stable from the REQ entry edge through RELEASE. A requester changing req_lba mid-transfer has no effect.
- A requester that drops rd/wr while in REQ does not cancel; the transfer completes as issued.
- sd_ack already high when entering REQ (bridge still finishing a prior transfer) is accepted as the ack. The bridge never does this under correct protocol, so it is not an error case.
- grant is at most NUM-1; indices at or above NUM are never generated.
- Async reset mid-transfer returns everything to reset values immediately, including deasserting sd_rd and sd_wr.
- Latency: request seen in IDLE → sd_rd/sd_wr high 1 cycle later. sd_ack rise → req_ack same cycle (combinational).

Test Plan:
- Single read: NUM=2, slot1 req_rd=1, req_lba=0x00001234, bridge acks 5 cycles later for 20 cycles → sd_rd high 1 cycle after the request, low on the ack edge; sd_lba=0x1234; req_ack=2'b10 for those 20 cycles; grant=1; busy returns 0 two cycles after ack falls.
- Contention/round-robin: slots 0 and 1 hold rd continuously from reset, bridge acks every request → grant sequence 0,1,0,1; neither req_ack ever shows the other slot's ack.
- Write data routing: slot0 req_wr=1 with req_buff_din=0xA5, slot1 req_buff_din=0x3C, bridge pulses sd_buff_wr 512 times during ack → sd_buff_din=0xA5 throughout; req_buff_wr[0] has 512 pulses, req_buff_wr[1] has 0.
- rd+wr together: slot0 req_rd=req_wr=1 → sd_wr=1, sd_rd=0.
- Timeout: TIMEOUT=100, slot0 req_rd held, no ack → sd_rd drops at cycle 100 of REQ; req_err[0] is a 1-cycle pulse; next grant goes to slot0 again only if it is the sole pending slot, otherwise to slot1.
- Reset mid-XFER: reset_n low while sd_ack=1 → sd_rd, sd_wr, busy, grant and req_ack are 0 asynchronously; after release, the next request starts from rr_ptr=0.
